// File: rtl/tpu_grad_unit.sv
// tpu_grad_unit: backward-pass gradient accumulator.
// Each beat gets a masked ReLU derivative (dz) in stage 1. Stage 2 adds
// dz*act and dz into the weight and bias accumulators. After BATCH beats
// the pipeline drains, and the scaled 16-bit gradient pair is offered on a
// valid/ready output.
// Optional macro GRAD_CLIP_EN: saturate the scaled result to the 16-bit
// range instead of truncating it.
module tpu_grad_unit #(
  parameter int BATCH    = 4,
  parameter int LR_SHIFT = 2,
  parameter int ACC_W    = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] grad_in,
  input  logic signed [15:0] pre_act,
  input  logic signed [15:0] act_in,
  input  logic               keep,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] grad_w,
  output logic signed [15:0] grad_b
);

  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [15:0]      dz_reg, act_reg;
  logic                    last_reg, s1_valid_reg;
  logic signed [ACC_W-1:0] acc_reg [2];
  logic [1:0][15:0]        grad_reg;
  logic                    out_valid_reg;

  logic                    accept, flush_now, cnt_last, out_fire, load_out;
  logic signed [15:0]      dz_next;
  logic signed [31:0]      prod;
  logic [1:0][ACC_W-1:0]   incr;
  logic [1:0][15:0]        result;

  assign in_ready  = (state_reg == ACCUM);
  assign accept    = in_valid && in_ready;
  // flush only has meaning while a batch is being collected
  assign flush_now = flush && (state_reg == ACCUM);
  assign cnt_last  = (cnt_reg == CNT_W'(BATCH - 1));
  assign out_fire  = out_valid_reg && out_ready;

  // Masked ReLU derivative: pass the gradient only for kept, positive pre-activations
  assign dz_next = (keep && (pre_act > 16'sd0)) ? grad_in : 16'sd0;
  assign prod    = dz_reg * act_reg;
  assign incr[0] = {{(ACC_W-32){prod[31]}}, prod};
  assign incr[1] = {{(ACC_W-16){dz_reg[15]}}, dz_reg};

  // Per-channel scaling and reduction of the accumulator to 16 bits
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
`ifdef GRAD_CLIP_EN
      localparam logic signed [ACC_W-1:0] MAX16 = {{(ACC_W-16){1'b0}}, 16'h7fff};
      localparam logic signed [ACC_W-1:0] MIN16 = {{(ACC_W-16){1'b1}}, 16'h8000};
      logic signed [ACC_W-1:0] shifted;
      logic [15:0]             res;
      assign shifted = acc_reg[gi] >>> LR_SHIFT;
      // Saturate the scaled value into the signed 16-bit range
      always_comb begin
        res = shifted[15:0];
        if (shifted > MAX16)
          res = 16'h7fff;
        else if (shifted < MIN16)
          res = 16'h8000;
      end
      assign result[gi] = res;
`else
      assign result[gi] = 16'(acc_reg[gi] >>> LR_SHIFT);
`endif
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= ACCUM;
    else
      state_reg <= state_next;
  end

  // Next state; DRAIN waits until the last beat has left stage 2
  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    case (state_reg)
      ACCUM: if (accept && !flush_now && cnt_last) state_next = DRAIN;
      DRAIN: begin
        if (!(s1_valid_reg && last_reg)) begin
          state_next = OUT;
          load_out   = 1'b1;
        end
      end
      OUT:   if (out_fire) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Stage 1 registers, beat counter, accumulators and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      dz_reg        <= '0;
      act_reg       <= '0;
      last_reg      <= 1'b0;
      s1_valid_reg  <= 1'b0;
      grad_reg      <= '0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 2; i++) acc_reg[i] <= '0;
    end else begin
      if (flush_now) begin
        cnt_reg      <= '0;
        dz_reg       <= '0;
        act_reg      <= '0;
        last_reg     <= 1'b0;
        s1_valid_reg <= 1'b0;
      end else if (accept) begin
        cnt_reg      <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
        dz_reg       <= dz_next;
        act_reg      <= act_in;
        last_reg     <= cnt_last;
        s1_valid_reg <= 1'b1;
      end else begin
        s1_valid_reg <= 1'b0;
      end

      for (int i = 0; i < 2; i++) begin
        if (flush_now || out_fire)
          acc_reg[i] <= '0;
        else if (s1_valid_reg)
          acc_reg[i] <= acc_reg[i] + incr[i];
      end

      if (out_fire) cnt_reg <= '0;

      if (load_out) begin
        grad_reg      <= result;
        out_valid_reg <= 1'b1;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign grad_w    = grad_reg[0];
  assign grad_b    = grad_reg[1];

endmodule

// File: tb/tb_tpu_grad_unit.sv
// Testbench for tpu_grad_unit (BATCH=4, LR_SHIFT=2).
// Batch vectors come from a table. Expected results are pushed to a
// scoreboard queue when a batch is driven and popped at the output
// handshake. Hand-written sequences cover stall, flush and reset.
module tb_tpu_grad_unit;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] grad_in;
  logic signed [15:0] pre_act;
  logic signed [15:0] act_in;
  logic               keep;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] grad_w;
  logic signed [15:0] grad_b;

  tpu_grad_unit #(.BATCH(4), .LR_SHIFT(2), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .grad_in(grad_in), .pre_act(pre_act), .act_in(act_in), .keep(keep),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .grad_w(grad_w), .grad_b(grad_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0]   g;
    logic [3:0][15:0]   p;
    logic [3:0][15:0]   a;
    logic [3:0]         k;
    logic signed [15:0] ew;
    logic signed [15:0] eb;
  } vec_t;

  typedef struct packed {
    logic signed [15:0] w;
    logic signed [15:0] b;
  } exp_t;

  localparam int NVEC = 7;
  vec_t vec [NVEC];
  exp_t sb_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic signed [15:0] g, input logic signed [15:0] p,
                         input logic signed [15:0] a, input logic signed [15:0] ew,
                         input logic signed [15:0] eb);
    for (int b = 0; b < 4; b++) begin
      vec[i].g[b] = g;
      vec[i].p[b] = p;
      vec[i].a[b] = a;
      vec[i].k[b] = 1'b1;
    end
    vec[i].ew = ew;
    vec[i].eb = eb;
  endtask

  // Drive one beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic signed [15:0] g, input logic signed [15:0] p,
                           input logic signed [15:0] a, input logic k);
    int n;
    n = 0;
    grad_in = g; pre_act = p; act_in = a; keep = k; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), compare against the scoreboard, handshake
  task automatic collect(input string name);
    int n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_out_valid"}, int'(out_valid), 1);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_grad_w"}, int'(grad_w), int'(e.w));
      chk({name, "_grad_b"}, int'(grad_b), int'(e.b));
      $display("batch %s: grad_w=%0d grad_b=%0d (exp %0d %0d)", name, grad_w, grad_b, e.w, e.b);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_valid_clr"}, int'(out_valid), 0);
    chk({name, "_ready_back"}, int'(in_ready), 1);
  endtask

  // Send a table vector with a latency check on out_valid
  task automatic send_vec(input int i);
    exp_t e;
    for (int b = 0; b < 4; b++)
      send_beat(vec[i].g[b], vec[i].p[b], vec[i].a[b], vec[i].k[b]);
    e.w = vec[i].ew;
    e.b = vec[i].eb;
    sb_q.push_back(e);
    chk("lat_t0", int'(out_valid), 0);
    chk("ready_drop", int'(in_ready), 0);
    step();
    chk("lat_t1", int'(out_valid), 0);
    step();
    chk("lat_t2", int'(out_valid), 1);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_grad_w", int'(grad_w), 0);
    chk("rst_grad_b", int'(grad_b), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    sb_q.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; grad_in = '0; pre_act = '0; act_in = '0;
    keep = 1'b0; flush = 1'b0; out_ready = 1'b0;

    set_vec(0, 16'sd100, 16'sd5, 16'sd8, 16'sd800, 16'sd100);
    set_vec(1, 16'sd100, 16'sd5, 16'sd8, 16'sd400, 16'sd50);
    vec[1].p[0] = 16'sd0;
    vec[1].p[1] = -16'sd3;
    set_vec(2, 16'sd100, 16'sd5, 16'sd8, 16'sd400, 16'sd50);
    vec[2].k[0] = 1'b0;
    vec[2].k[1] = 1'b0;
`ifdef GRAD_CLIP_EN
    set_vec(3, 16'sd32767, 16'sd1, 16'sd32767, 16'sd32767, 16'sd32767);
`else
    set_vec(3, 16'sd32767, 16'sd1, 16'sd32767, 16'sd1, 16'sd32767);
`endif
    set_vec(4, -16'sd50, 16'sd7, 16'sd3, -16'sd150, -16'sd50);
    set_vec(5, 16'sd20, 16'sd2, -16'sd9, -16'sd180, 16'sd20);
    set_vec(6, -16'sd1, 16'sd1, 16'sd1, -16'sd1, -16'sd1);
    vec[6].k[3] = 1'b0;

    #2;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_grad_w", int'(grad_w), 0);
    chk("init_grad_b", int'(grad_b), 0);
    chk("init_in_ready", int'(in_ready), 1);
    step();
    reset = 1'b0;
    step();

    // Table-driven batches
    for (int i = 0; i < NVEC; i++) begin
      send_vec(i);
      collect($sformatf("vec%0d", i));
    end

    // Consumer stall: outputs hold, input ignored
    send_vec(0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; grad_in = 16'sd999; pre_act = 16'sd1; act_in = 16'sd9; keep = 1'b1;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_grad_w", int'(grad_w), 800);
      chk("stall_grad_b", int'(grad_b), 100);
      chk("stall_in_ready", int'(in_ready), 0);
      step();
      in_valid = 1'b0;
    end
    collect("stall");
    send_vec(4);
    collect("after_stall");

    // Flush after two beats; the flushed beat is dropped
    send_beat(16'sd100, 16'sd5, 16'sd8, 1'b1);
    send_beat(16'sd100, 16'sd5, 16'sd8, 1'b1);
    in_valid = 1'b1; flush = 1'b1; grad_in = 16'sd1000; pre_act = 16'sd5; act_in = 16'sd8; keep = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_in_ready", int'(in_ready), 1);
    chk("flush_no_valid", int'(out_valid), 0);
    for (int b = 0; b < 4; b++) send_beat(16'sd10, 16'sd1, 16'sd4, 1'b1);
    sb_q.push_back({16'sd40, 16'sd10});
    collect("flush");

    // Reset after two beats, then a fresh batch
    send_beat(16'sd100, 16'sd5, 16'sd8, 1'b1);
    send_beat(16'sd100, 16'sd5, 16'sd8, 1'b1);
    do_reset();
    send_vec(0);
    collect("rst_mid");

    // Reset while holding a result in OUT
    send_vec(5);
    step();
    chk("pre_rst_valid", int'(out_valid), 1);
    do_reset();
    chk("post_rst_valid", int'(out_valid), 0);
    send_vec(1);
    collect("rst_out");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_grad_unit.md
# tpu_grad_unit

Backward-pass companion to the forward TPU datapath: consumes a stream of upstream gradients with the matching stored pre-activations, input activations and dropout keep bits. Computes the masked ReLU derivative per element and accumulates weight and bias gradients over a batch. Emits one scaled 16-bit gradient pair per batch through a valid/ready handshake. Sits between the loss/error stream and the weight-update logic.

## Interface
- BATCH, 4, samples per gradient batch (1..256)
- LR_SHIFT, 2, arithmetic right shift applied to both accumulators (0..15)
- ACC_W, 40, accumulator width in bits (≥ 32 + log2(BATCH))
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- grad_in  input  16  upstream gradient, signed two's complement
- pre_act  input  16  stored pre-activation (multiplier low 16 bits), signed
- act_in  input  16  layer input activation, signed
- keep  input  1  dropout keep bit (0 = element dropped)
- flush  input  1  synchronous; discard partial batch
- out_valid  output  1  gradient result valid
- out_ready  input  1  consumer accepts result
- grad_w  output  16  scaled weight gradient, signed
- grad_b  output  16  scaled bias gradient, signed

## Operation
- States: ACCUM, DRAIN, OUT. Reset state ACCUM.
- A beat is accepted when in_valid && in_ready. in_ready = 1 only in ACCUM.
- Stage 1 (accept edge): dz = (keep && pre_act > 0, signed compare) ? grad_in : 0. Register dz, act_in, and a last flag (beat count == BATCH-1).
- Stage 2 (next edge): acc_w += sext(dz*act_in) (32-bit signed product); acc_b += sext(dz).
- The beat counter increments per accepted beat. On the BATCH-th accept, it wraps to 0 and the FSM goes ACCUM→DRAIN; in_ready drops the cycle after.
- In DRAIN, stage 2 completes the last update. On the next edge, grad_w/grad_b load and out_valid sets; the FSM moves DRAIN→OUT.
- Output formation: r = acc >>> LR_SHIFT, then reduce to 16 bits per Configuration.
- In OUT, outputs hold stable while out_ready = 0. On out_valid && out_ready: clear out_valid, acc_w, acc_b and the counter; go OUT→ACCUM, so in_ready = 1 the following cycle.
- flush is honoured in ACCUM only and ignored in DRAIN/OUT. It clears the counter, both accumulators and the stage-1 registers, and any beat accepted that same cycle is dropped.

## Timing
- Reset values: in_ready 1, out_valid 0, grad_w 0, grad_b 0. Accumulators, counter and pipeline registers are 0.
- Latency: last beat accepted at edge t → out_valid high after edge t+2.
- Throughput: 1 beat/cycle within a batch. Batch-to-batch gap ≥ 3 cycles plus consumer stall.
- Reset mid-batch or mid-OUT aborts all state immediately; no result is emitted for the partial batch.
- in_valid while in_ready = 0 is ignored; the producer must hold the beat.
- out_ready while out_valid = 0 has no effect.

## Configuration
- GRAD_CLIP_EN defined: r saturates to [-32768, 32767] before output.
- Undefined: grad_w/grad_b = r[15:0], wrapping two's complement truncation.
- Accumulators never saturate in either mode.

## Test plan
- BATCH=4, LR_SHIFT=2; 4 beats grad_in=100, pre_act=5, act_in=8, keep=1 → out_valid 2 cycles after 4th accept, grad_w=800, grad_b=100.
- Same stimulus but pre_act=0 on beat 1 and pre_act=-3 on beat 2 → grad_w=400, grad_b=50. Repeat with keep=0 on those beats instead → same result.
- 4 beats grad_in=32767, pre_act=1, act_in=32767 → with GRAD_CLIP_EN: grad_w=32767, grad_b=32767. Without: grad_w=16'h0001, grad_b=32767.
- Complete batch with out_ready held low 5 cycles → out_valid, grad_w and grad_b stable throughout; in_ready=0; in_valid pulses ignored. After the handshake, in_ready=1 the next cycle and the next batch accumulates from 0.
- 2 beats accepted then flush=1 with in_valid=1 → flushed beat dropped. Next 4 beats (grad_in=10, pre_act=1, act_in=4) → grad_w=40, grad_b=10.
- Assert reset after 2 beats, and separately during OUT → all outputs 0, in_ready=1. A fresh 4-beat batch produces the correct result from a zero count.
